rp_mask_row_expander: RTL and testbench
=======================================

// Module: rp_mask_row_expander
// PURPOSE
// - MG-side receiver for the repeat-pattern row interface (load_pattern / pattern / rp_valid).
// - Buffers 32-bit row patterns in a FIFO and tiles each row's first pattern_w bits across image_sensor_w.
// - Streams OUT_W mask bits per beat to the pixel-mask driver over a valid/ready handshake.
// - Counts lines and flags end of line and end of frame.
// PARAMETERS
// - OUT_W       16  mask bits per output beat (1..32)
// - FIFO_DEPTH  2   row-pattern FIFO entries (power of 2, >=2)
// PORTS
// - clk             in   1      clock
// - rst             in   1      asynchronous reset, active-high
// - clk_en          in   1      global enable; all state frozen when low
// - image_sensor_w  in   11     active pixels per line (1..1920)
// - image_sensor_h  in   11     lines per frame (1..1080)
// - pattern_w       in   5      repeat period in bits; 0 = 32
// - load_pattern    in   1      row-pattern write strobe from scheduler
// - pattern         in   [0:31] row pattern; bit 0 = leftmost pixel
// - rp_valid        out  1      FIFO can accept a row (registered, = !full)
// - mask_data       out  OUT_W  mask bits; bit 0 = lowest column of beat
// - mask_valid      out  1      mask_data valid
// - mask_ready      in   1      downstream accepts beat
// - mask_eol        out  1      current beat is last of line
// - mask_eof        out  1      current beat is last of frame
// - ovf_err         out  1      sticky: write attempted while FIFO full
// BEHAVIOUR
// - Reset values: rp_valid=1, mask_data=0, mask_valid=0, mask_eol=0, mask_eof=0, ovf_err=0.
// - Reset also clears FIFO, col, phase and line counters; state=IDLE. Reset mid-line discards the row.
// - Write: clk_en & load_pattern & rp_valid -> push pattern. Visible at FIFO head next cycle.
// - Full write: load_pattern while !rp_valid -> data dropped, ovf_err set until rst.
// - Simultaneous push and pop on a full FIFO: pop takes effect first, push is accepted, no ovf.
// - eff_w = (pattern_w==0) ? 32 : pattern_w.
// - pattern_w, image_sensor_w and image_sensor_h are sampled at each line start; ignored mid-line.
// - FSM states:
//   - IDLE: FIFO empty; mask_valid=0.
//   - LOAD: pop head into row_reg; col=0, phase=0.
//   - EMIT: drive the current beat.
// - FSM transitions:
//   - IDLE -> LOAD when FIFO not empty.
//   - LOAD -> EMIT after 1 cycle. Latency from push into an empty FIFO to first mask_valid = 3 cycles.
//   - EMIT -> EMIT on beat accept (mask_valid & mask_ready & clk_en) when not last beat.
//   - EMIT -> LOAD on last beat of line if FIFO not empty, else -> IDLE.
// - Beat generation:
//   - mask_data[k] = row_reg[(phase+k) mod eff_w] for col+k < image_sensor_w.
//   - Bits with col+k >= image_sensor_w are 0 (last-beat padding).
// - On accept: col += OUT_W; phase = (phase+OUT_W) mod eff_w (6-bit arithmetic, no overflow).
// - Beats per line = ceil(image_sensor_w/OUT_W).
//   - mask_eol=1 on the final beat.
//   - line counter increments when that beat is accepted.
// - mask_eof=1 on the final beat of line image_sensor_h-1; accepting it wraps the line counter to 0.
// - mask_valid/mask_data/flags hold stable while mask_valid & !mask_ready (AXI-style; no retraction).
// CONFIGURATION
// - RP_MG_LAST_ROW_REPEAT_EN defined:
//   - At line end with FIFO empty, go to EMIT and reuse row_reg; no IDLE stall.
//   - A row must have been loaded since reset before this applies.
// - Undefined: FSM stalls in IDLE until the next row arrives.
// TESTING
// - Tiling: w=40, OUT_W=16, pattern_w=3, pattern=101... -> 3 beats, tiled 101 period continuing across beats; beat 3 bits 8..15 = 0; eol on beat 3.
// - Period 32: pattern_w=0, w=64 -> two beats carrying pattern[0:15] and pattern[16:31], then repeats.
// - Frame wrap: h=2, w=16, push 3 rows -> eof on line 1 beat only; line 3 has eol, no eof.
// - Backpressure: mask_ready low 5 cycles mid-line -> data and flags held constant, no beat lost.
// - Overflow: FIFO_DEPTH=2, no mask_ready, push 3 rows -> rp_valid=0 after 2; 3rd dropped; ovf_err=1.
// - Reset and clk_en: rst mid-beat -> all outputs at reset values next cycle; clk_en low 4 cycles -> no state change.

Source files
------------

// File: rtl/rp_mask_row_expander_if.sv
// Repeat-pattern row bus between the scheduler/pixel-mask driver (master side)
// and the mask row expander (slave side).
//
// Handshake rules:
//   Row input  : a row is taken on a clock where load_pattern is high and
//                rp_valid is high (or the expander frees a slot that same
//                clock). rp_valid is registered and equals !full.
//   Mask output: a beat transfers on a clock where mask_valid and mask_ready
//                are both high. Once mask_valid rises, mask_valid, mask_data,
//                mask_eol and mask_eof stay unchanged until that transfer;
//                a beat is never retracted.
interface rp_mask_row_expander_if #(
    parameter int OUT_W = 16
);
    logic             load_pattern;
    logic [0:31]      pattern;
    logic             rp_valid;
    logic [OUT_W-1:0] mask_data;
    logic             mask_valid;
    logic             mask_ready;
    logic             mask_eol;
    logic             mask_eof;
    logic             ovf_err;

    modport master (
        output load_pattern, pattern, mask_ready,
        input  rp_valid, mask_data, mask_valid, mask_eol, mask_eof, ovf_err
    );

    modport slave (
        input  load_pattern, pattern, mask_ready,
        output rp_valid, mask_data, mask_valid, mask_eol, mask_eof, ovf_err
    );
endinterface

// File: rtl/rp_mask_row_expander.sv
// Mask row expander: buffers 32-bit row patterns and tiles the first
// pattern_w bits of each row across image_sensor_w pixels. The result is
// streamed as OUT_W-bit beats with end-of-line and end-of-frame flags.
// Optional feature macro: RP_MG_LAST_ROW_REPEAT_EN. When it is defined, the
// last loaded row is replayed if no new row is waiting at line end.
module rp_mask_row_expander #(
    parameter int OUT_W      = 16,
    parameter int FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clk_en,
    input  logic [10:0] image_sensor_w,
    input  logic [10:0] image_sensor_h,
    input  logic [4:0]  pattern_w,
    rp_mask_row_expander_if.slave bus,
    output logic [1:0]  state_dbg
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        EMIT = 2'd2
    } state_t;

    state_t          state, state_next;

    logic [0:31]     fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count, count_next;
    logic            fifo_empty;
    logic            rp_valid_q;
    logic            ovf_q;
    logic            push, pop, ovf_set;

    logic [0:31]     row_reg;
    logic [11:0]     col;
    logic [5:0]      phase, phase_adv;
    logic [5:0]      eff_w_reg, eff_w_in;
    logic [10:0]     w_reg, h_reg, line_cnt;
    logic            beat_accept, last_beat, last_line;
    logic            repeat_ok, restart_line;
    logic [OUT_W-1:0] mask_data_c;
    logic [4:0]      tap;

    assign fifo_empty = (count == '0);
    assign pop        = clk_en && (state == LOAD);
    // A slot freed by this clock's pop can take the incoming row at once.
    assign push       = clk_en && bus.load_pattern && (rp_valid_q || pop);
    assign ovf_set    = clk_en && bus.load_pattern && !rp_valid_q && !pop;

    always_comb begin
        count_next = count;
        if (push && !pop)      count_next = count + CW'(1);
        else if (!push && pop) count_next = count - CW'(1);
    end

    // FIFO pointers, occupancy, registered ready and sticky overflow flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            rp_valid_q <= 1'b1;
            ovf_q      <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count      <= count_next;
            rp_valid_q <= (count_next != CW'(FIFO_DEPTH));
            if (ovf_set) ovf_q <= 1'b1;
        end
    end

    // FIFO storage; contents need no reset because occupancy guards reads.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= bus.pattern;
    end

    assign eff_w_in    = (pattern_w == 5'd0) ? 6'd32 : {1'b0, pattern_w};
    assign beat_accept = (state == EMIT) && bus.mask_ready && clk_en;
    assign last_beat   = (13'(col) + 13'(OUT_W)) >= 13'(w_reg);
    assign last_line   = (line_cnt == (h_reg - 11'd1));
    assign phase_adv   = (phase + 6'(OUT_W)) % eff_w_reg;

`ifdef RP_MG_LAST_ROW_REPEAT_EN
    logic have_row;

    // Remembers that row_reg holds a real row, so a replay is meaningful.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                          have_row <= 1'b0;
        else if (clk_en && state == LOAD) have_row <= 1'b1;
    end

    assign repeat_ok = have_row;
`else
    assign repeat_ok = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         state <= IDLE;
        else if (clk_en) state <= state_next;
    end

    // Next state; restart_line marks an in-place replay of row_reg.
    always_comb begin
        state_next   = state;
        restart_line = 1'b0;
        case (state)
            IDLE: if (!fifo_empty) state_next = LOAD;
            LOAD: state_next = EMIT;
            EMIT: begin
                if (beat_accept && last_beat) begin
                    if (!fifo_empty) begin
                        state_next = LOAD;
                    end else if (repeat_ok) begin
                        state_next   = EMIT;
                        restart_line = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Line datapath: row capture, geometry sampling at line start, column,
    // tiling phase and line counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_reg   <= '0;
            col       <= '0;
            phase     <= '0;
            eff_w_reg <= 6'd32;
            w_reg     <= '0;
            h_reg     <= 11'd1;
            line_cnt  <= '0;
        end else if (clk_en) begin
            if (state == LOAD) begin
                row_reg   <= fifo_mem[rd_ptr];
                col       <= '0;
                phase     <= '0;
                eff_w_reg <= eff_w_in;
                w_reg     <= image_sensor_w;
                h_reg     <= image_sensor_h;
            end else if (beat_accept) begin
                if (last_beat) line_cnt <= last_line ? 11'd0 : line_cnt + 11'd1;
                if (restart_line) begin
                    col       <= '0;
                    phase     <= '0;
                    eff_w_reg <= eff_w_in;
                    w_reg     <= image_sensor_w;
                    h_reg     <= image_sensor_h;
                end else begin
                    col   <= col + 12'(OUT_W);
                    phase <= phase_adv;
                end
            end
        end
    end

    // Beat assembly: tile row_reg from the current phase, zero past line end.
    always_comb begin
        mask_data_c = '0;
        tap         = '0;
        if (state == EMIT) begin
            for (int k = 0; k < OUT_W; k++) begin
                tap = 5'((phase + 6'(k)) % eff_w_reg);
                if ((col + 12'(k)) < {1'b0, w_reg}) mask_data_c[k] = row_reg[tap];
            end
        end
    end

    assign bus.rp_valid   = rp_valid_q;
    assign bus.ovf_err    = ovf_q;
    assign bus.mask_valid = (state == EMIT);
    assign bus.mask_data  = mask_data_c;
    assign bus.mask_eol   = (state == EMIT) && last_beat;
    assign bus.mask_eof   = (state == EMIT) && last_beat && last_line;
    assign state_dbg      = state;
endmodule

// File: tb/tb_rp_mask_row_expander.sv
// Directed bench for rp_mask_row_expander (OUT_W=16, FIFO_DEPTH=2, default
// build). Expected beats are hand-tiled from the row patterns.
module tb_rp_mask_row_expander;
    logic        clk;
    logic        rst;
    logic        clk_en;
    logic [10:0] image_sensor_w;
    logic [10:0] image_sensor_h;
    logic [4:0]  pattern_w;
    logic [1:0]  state_dbg;

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;

    rp_mask_row_expander_if #(.OUT_W(16)) bus ();

    rp_mask_row_expander #(
        .OUT_W(16),
        .FIFO_DEPTH(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .clk_en(clk_en),
        .image_sensor_w(image_sensor_w),
        .image_sensor_h(image_sensor_h),
        .pattern_w(pattern_w),
        .bus(bus),
        .state_dbg(state_dbg)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    // Driver
    task automatic push(input logic [31:0] p);
        bus.load_pattern = 1'b1;
        bus.pattern      = p;
        tick();
        bus.load_pattern = 1'b0;
    endtask

    // Checks
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_beat(input string tag, input logic v, input logic [15:0] d,
                              input logic eol, input logic eof);
        check({tag, ".valid"}, 32'(bus.mask_valid), 32'(v));
        check({tag, ".data"},  32'(bus.mask_data),  32'(d));
        check({tag, ".eol"},   32'(bus.mask_eol),   32'(eol));
        check({tag, ".eof"},   32'(bus.mask_eof),   32'(eof));
    endtask

    initial begin
        rst              = 1'b1;
        clk_en           = 1'b1;
        image_sensor_w   = 11'd40;
        image_sensor_h   = 11'd4;
        pattern_w        = 5'd3;
        bus.load_pattern = 1'b0;
        bus.pattern      = '0;
        bus.mask_ready   = 1'b1;
        tick();
        tick();

        // Reset values
        check_beat("rst", 1'b0, 16'h0000, 1'b0, 1'b0);
        check("rst.rp_valid", 32'(bus.rp_valid), 32'd1);
        check("rst.ovf", 32'(bus.ovf_err), 32'd0);
        check("rst.state", 32'(state_dbg), 32'd0);
        rst = 1'b0;
        tick();

        // Tiling: w=40, period 3, pattern 101
        push(32'hA000_0000);
        check("lat.c1", 32'(bus.mask_valid), 32'd0);
        tick();
        check("lat.c2", 32'(bus.mask_valid), 32'd0);
        tick();
        check_beat("tile.b0", 1'b1, 16'hDB6D, 1'b0, 1'b0);
        tick();
        check_beat("tile.b1", 1'b1, 16'h6DB6, 1'b0, 1'b0);
        tick();
        check_beat("tile.b2", 1'b1, 16'h00DB, 1'b1, 1'b0);
        tick();
        check("tile.idle", 32'(bus.mask_valid), 32'd0);

        // Period 32 with backpressure on beat 1
        pattern_w      = 5'd0;
        image_sensor_w = 11'd64;
        bus.mask_ready = 1'b0;
        push(32'h1234_5678);
        tick();
        tick();
        check_beat("p32.b0", 1'b1, 16'h2C48, 1'b0, 1'b0);
        bus.mask_ready = 1'b1;
        tick();
        check_beat("p32.b1", 1'b1, 16'h1E6A, 1'b0, 1'b0);
        bus.mask_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_beat("bp.hold", 1'b1, 16'h1E6A, 1'b0, 1'b0);
        end
        bus.mask_ready = 1'b1;
        tick();
        check_beat("p32.b2", 1'b1, 16'h2C48, 1'b0, 1'b0);
        tick();
        check_beat("p32.b3", 1'b1, 16'h1E6A, 1'b1, 1'b0);
        tick();
        check("p32.idle", 32'(bus.mask_valid), 32'd0);

        // Frame wrap: h=2, w=16, three rows
        do_reset();
        image_sensor_h = 11'd2;
        image_sensor_w = 11'd16;
        pattern_w      = 5'd4;
        push(32'hC000_0000);
        push(32'h8000_0000);
        check("fw.full", 32'(bus.rp_valid), 32'd0);
        tick();
        check_beat("fw.l0", 1'b1, 16'h3333, 1'b1, 1'b0);
        check("fw.rp_valid", 32'(bus.rp_valid), 32'd1);
        push(32'hF000_0000);
        check("fw.load", 32'(bus.mask_valid), 32'd0);
        tick();
        check_beat("fw.l1", 1'b1, 16'h1111, 1'b1, 1'b1);
        tick();
        tick();
        check_beat("fw.l2", 1'b1, 16'hFFFF, 1'b1, 1'b0);
        tick();
        check("fw.idle", 32'(bus.mask_valid), 32'd0);

        // Overflow: no ready, fill FIFO behind a held beat, then drop a row
        do_reset();
        image_sensor_h = 11'd8;
        bus.mask_ready = 1'b0;
        check("ovf.clear", 32'(bus.ovf_err), 32'd0);
        push(32'hC000_0000);
        tick();
        tick();
        check_beat("ovf.r1", 1'b1, 16'h3333, 1'b1, 1'b0);
        push(32'h8000_0000);
        push(32'hF000_0000);
        check("ovf.full", 32'(bus.rp_valid), 32'd0);
        check("ovf.none", 32'(bus.ovf_err), 32'd0);
        push(32'hA000_0000);
        check("ovf.set", 32'(bus.ovf_err), 32'd1);
        bus.mask_ready = 1'b1;
        tick();
        check("ovf.load", 32'(bus.mask_valid), 32'd0);
        push(32'h6000_0000);
        check_beat("ovf.r2", 1'b1, 16'h1111, 1'b1, 1'b0);
        check("popush.full", 32'(bus.rp_valid), 32'd0);
        tick();
        tick();
        check_beat("ovf.r3", 1'b1, 16'hFFFF, 1'b1, 1'b0);
        check("ovf.rp_valid", 32'(bus.rp_valid), 32'd1);
        tick();
        tick();
        check_beat("popush.r5", 1'b1, 16'h6666, 1'b1, 1'b0);
        tick();
        check("ovf.dropped", 32'(bus.mask_valid), 32'd0);
        check("ovf.sticky", 32'(bus.ovf_err), 32'd1);

        // clk_en freeze, then reset mid-line
        do_reset();
        check("ce.ovf_clear", 32'(bus.ovf_err), 32'd0);
        image_sensor_w = 11'd40;
        image_sensor_h = 11'd4;
        pattern_w      = 5'd3;
        bus.mask_ready = 1'b0;
        push(32'hA000_0000);
        tick();
        tick();
        check_beat("ce.b0", 1'b1, 16'hDB6D, 1'b0, 1'b0);
        clk_en           = 1'b0;
        bus.mask_ready   = 1'b1;
        bus.load_pattern = 1'b1;
        bus.pattern      = 32'hFFFF_FFFF;
        for (int i = 0; i < 4; i++) tick();
        check_beat("ce.hold", 1'b1, 16'hDB6D, 1'b0, 1'b0);
        check("ce.state", 32'(state_dbg), 32'd2);
        clk_en           = 1'b1;
        bus.load_pattern = 1'b0;
        tick();
        check_beat("ce.b1", 1'b1, 16'h6DB6, 1'b0, 1'b0);
        tick();
        check_beat("ce.b2", 1'b1, 16'h00DB, 1'b1, 1'b0);
        tick();
        check("ce.no_push", 32'(bus.mask_valid), 32'd0);

        push(32'hA000_0000);
        tick();
        tick();
        tick();
        check_beat("rm.b1", 1'b1, 16'h6DB6, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        check_beat("rm.rst", 1'b0, 16'h0000, 1'b0, 1'b0);
        check("rm.rp_valid", 32'(bus.rp_valid), 32'd1);
        check("rm.state", 32'(state_dbg), 32'd0);
        rst = 1'b0;
        tick();
        tick();
        tick();
        check("rm.discard", 32'(bus.mask_valid), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
